// File: rtl/struct_lane_regfile.sv
// Register file stored as a packed struct {msb, data[0:NLANES-1], lsb}.
// It has one write port and one registered read port per cycle, with range checks and a saturating error counter.
module struct_lane_regfile #(
   parameter int                LANE_W    = 8,
   parameter int                NLANES    = 4,
   parameter int                ADDR_W    = 3,
   parameter int                WR_BYPASS = 0,
   parameter logic [LANE_W-1:0] FILL      = '1,
   parameter int                CNT_W     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [LANE_W-1:0]            wr_data,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [LANE_W-1:0]            rd_data,
   output logic                         rd_valid,
   output logic                         rd_oob,
   output logic                         wr_oob,
   output logic [CNT_W-1:0]             oob_cnt,
   output logic [(NLANES+2)*LANE_W-1:0] s_o
);

   typedef struct packed {
      logic [LANE_W-1:0]                msb;
      logic [0:NLANES-1][LANE_W-1:0]    data;
      logic [LANE_W-1:0]                lsb;
   } regs_t;

   localparam logic [ADDR_W:0]  NL_EXT  = (ADDR_W+1)'(NLANES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   regs_t             s_q, s_d;
   logic [LANE_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_oob_q, rd_oob_d;
   logic              wr_oob_q, wr_oob_d;
   logic [CNT_W-1:0]  oob_cnt_q, oob_cnt_d;
   logic [CNT_W+1:0]  cnt_sum;
   logic [LANE_W-1:0] rd_lane;
   logic              wr_in_range;
   logic              rd_in_range;

   // The address is widened by one bit so the check stays correct when NLANES == 2**ADDR_W.
   assign wr_in_range = {1'b0, wr_addr} < NL_EXT;
   assign rd_in_range = {1'b0, rd_addr} < NL_EXT;

   // Lanes are selected by comparing the address against each lane index.
   // This mux gives the same result whether it is lowered as shift/mask or as a case, and it never indexes past the array.
   always_comb begin
      s_d     = s_q;
      s_d.msb = '1;
      s_d.lsb = '1;
      if (clr) begin
         for (int i = 0; i < NLANES; i++) begin
            s_d.data[i] = FILL;
         end
      end else if (wr_en && wr_in_range) begin
         for (int i = 0; i < NLANES; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
               s_d.data[i] = wr_data;
            end
         end
      end
   end

   always_comb begin
      rd_lane = FILL;
      for (int i = 0; i < NLANES; i++) begin
         if (rd_addr == ADDR_W'(i)) begin
            rd_lane = s_q.data[i];
         end
      end
      // A write that clr drops in the same cycle is not forwarded to the read.
      if ((WR_BYPASS != 0) && wr_en && !clr && wr_in_range && (wr_addr == rd_addr)) begin
         rd_lane = wr_data;
      end

      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      rd_oob_d   = rd_en && !rd_in_range;
      wr_oob_d   = wr_en && !wr_in_range;
      if (rd_en) begin
         rd_data_d = rd_in_range ? rd_lane : FILL;
      end

      cnt_sum   = {2'b00, oob_cnt_q} + (CNT_W+2)'(rd_oob_d) + (CNT_W+2)'(wr_oob_d);
      oob_cnt_d = (cnt_sum > {2'b00, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q        <= '1;
         rd_data_q  <= FILL;
         rd_valid_q <= 1'b0;
         rd_oob_q   <= 1'b0;
         wr_oob_q   <= 1'b0;
         oob_cnt_q  <= '0;
      end else begin
         s_q        <= s_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_oob_q   <= rd_oob_d;
         wr_oob_q   <= wr_oob_d;
         oob_cnt_q  <= oob_cnt_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_oob   = rd_oob_q;
   assign wr_oob   = wr_oob_q;
   assign oob_cnt  = oob_cnt_q;
   assign s_o      = s_q;

endmodule

// File: tb/tb_struct_lane_regfile.sv
// Drives two register-file instances with identical stimulus every cycle:
// the default build, and a build with NLANES=6, LANE_W=16 and write bypass enabled.
module tb_struct_lane_regfile;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         a_rst, a_clr, a_wr_en, a_rd_en;
   logic [2:0]   a_wr_addr, a_rd_addr;
   logic [7:0]   a_wr_data, a_rd_data;
   logic         a_rd_valid, a_rd_oob, a_wr_oob;
   logic [3:0]   a_oob_cnt;
   logic [47:0]  a_s_o;

   logic         b_rst, b_clr, b_wr_en, b_rd_en;
   logic [2:0]   b_wr_addr, b_rd_addr;
   logic [15:0]  b_wr_data, b_rd_data;
   logic         b_rd_valid, b_rd_oob, b_wr_oob;
   logic [3:0]   b_oob_cnt;
   logic [127:0] b_s_o;

   int tests_run = 0;
   int fails     = 0;

   struct_lane_regfile dut_a (
      .clk(clk), .rst(a_rst), .clr(a_clr), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
      .wr_data(a_wr_data), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .rd_valid(a_rd_valid), .rd_oob(a_rd_oob), .wr_oob(a_wr_oob), .oob_cnt(a_oob_cnt),
      .s_o(a_s_o)
   );

   struct_lane_regfile #(.LANE_W(16), .NLANES(6), .ADDR_W(3), .WR_BYPASS(1)) dut_b (
      .clk(clk), .rst(b_rst), .clr(b_clr), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .wr_data(b_wr_data), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .rd_valid(b_rd_valid), .rd_oob(b_rd_oob), .wr_oob(b_wr_oob), .oob_cnt(b_oob_cnt),
      .s_o(b_s_o)
   );

   // Reference model: index 0 is dut_a, index 1 is dut_b.
   logic [15:0] m_lane [2][6];
   logic [15:0] m_rd   [2];
   bit          m_valid[2];
   bit          m_rdoob[2];
   bit          m_wroob[2];
   int          m_cnt  [2];

   function automatic void model_step(int d, logic rst_i, logic clr_i, logic we_i, int wa,
                                      logic [15:0] wd, logic re_i, int ra);
      logic [15:0] mask = (d == 0) ? 16'h00ff : 16'hffff;
      int          nl   = (d == 0) ? 4 : 6;
      bit          byp  = (d == 1);
      int          add  = 0;
      if (rst_i) begin
         for (int i = 0; i < 6; i++) m_lane[d][i] = mask;
         m_rd[d] = mask; m_valid[d] = 0; m_rdoob[d] = 0; m_wroob[d] = 0; m_cnt[d] = 0;
         return;
      end
      m_valid[d] = re_i;
      m_rdoob[d] = re_i && (ra >= nl);
      if (re_i) begin
         if (ra >= nl) begin
            m_rd[d] = mask;
            add++;
         end else if (byp && we_i && !clr_i && wa == ra) begin
            m_rd[d] = wd & mask;
         end else begin
            m_rd[d] = m_lane[d][ra];
         end
      end
      m_wroob[d] = we_i && (wa >= nl);
      if (m_wroob[d]) add++;
      m_cnt[d] = (m_cnt[d] + add > 15) ? 15 : m_cnt[d] + add;
      if (clr_i) begin
         for (int i = 0; i < 6; i++) m_lane[d][i] = mask;
      end else if (we_i && wa < nl) begin
         m_lane[d][wa] = wd & mask;
      end
   endfunction

   function automatic logic [127:0] exp_s(int d);
      logic [127:0] s;
      int nl = (d == 0) ? 4 : 6;
      int lw = (d == 0) ? 8 : 16;
      logic [15:0] mask = (d == 0) ? 16'h00ff : 16'hffff;
      s = {112'd0, mask};
      for (int i = 0; i < nl; i++) s = (s << lw) | {112'd0, m_lane[d][i]};
      s = (s << lw) | {112'd0, mask};
      return s;
   endfunction

   task automatic cyc(input logic rst_i, input logic clr_i, input logic we_i, input logic [2:0] wa_i,
                      input logic [15:0] wd_i, input logic re_i, input logic [2:0] ra_i);
      a_rst = rst_i; a_clr = clr_i; a_wr_en = we_i; a_wr_addr = wa_i; a_wr_data = wd_i[7:0];
      a_rd_en = re_i; a_rd_addr = ra_i;
      b_rst = rst_i; b_clr = clr_i; b_wr_en = we_i; b_wr_addr = wa_i; b_wr_data = wd_i;
      b_rd_en = re_i; b_rd_addr = ra_i;
      @(posedge clk);
      model_step(0, rst_i, clr_i, we_i, int'(wa_i), wd_i, re_i, int'(ra_i));
      model_step(1, rst_i, clr_i, we_i, int'(wa_i), wd_i, re_i, int'(ra_i));
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (a_s_o !== 48'hffff_ffff_ffff) begin
         fails++; $display("[TB] FAIL reset_s_o: got %h expected %h", a_s_o, 48'hffff_ffff_ffff);
      end
      tests_run++;
      if ({a_rd_valid, a_rd_oob, a_wr_oob, a_oob_cnt, a_rd_data} !== {3'b000, 4'h0, 8'hff}) begin
         fails++; $display("[TB] FAIL reset_flags: got v%b r%b w%b c%h d%h expected 0 0 0 0 ff",
                           a_rd_valid, a_rd_oob, a_wr_oob, a_oob_cnt, a_rd_data);
      end
      tests_run++;
      if (b_s_o !== {128{1'b1}}) begin
         fails++; $display("[TB] FAIL reset_b_s_o: got %h expected all ones", b_s_o);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 1, 3'(i));
         tests_run++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hff) begin
            fails++; $display("[TB] FAIL reset_read%0d: got v%b d%h expected v1 dff", i, a_rd_valid, a_rd_data);
         end
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (a_rd_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_valid_pulse: got %b expected 0", a_rd_valid);
      end
   endtask

   task automatic test_write_read();
      cyc(0, 0, 1, 3'd1, 16'h007e, 0, 0);
      tests_run++;
      if (a_s_o !== 48'hffff_7eff_ffff) begin
         fails++; $display("[TB] FAIL write_s_o: got %h expected %h", a_s_o, 48'hffff_7eff_ffff);
      end
      cyc(0, 0, 0, 0, 0, 1, 3'd1);
      tests_run++;
      if (a_rd_data !== 8'h7e) begin
         fails++; $display("[TB] FAIL read_lane1: got %h expected 7e", a_rd_data);
      end
      cyc(0, 0, 0, 0, 0, 1, 3'd2);
      tests_run++;
      if (a_rd_data !== 8'hff) begin
         fails++; $display("[TB] FAIL read_lane2: got %h expected ff", a_rd_data);
      end
   endtask

   task automatic test_oob();
      cyc(0, 0, 1, 3'd4, 16'h0000, 0, 0);
      tests_run++;
      if (a_s_o !== 48'hffff_7eff_ffff || a_wr_oob !== 1'b1 || a_oob_cnt !== 4'd1) begin
         fails++; $display("[TB] FAIL oob_write: got s%h w%b c%0d expected s ffff7effffff w1 c1",
                           a_s_o, a_wr_oob, a_oob_cnt);
      end
      cyc(0, 0, 0, 0, 0, 1, 3'd4);
      tests_run++;
      if (a_rd_data !== 8'hff || a_rd_oob !== 1'b1 || a_rd_valid !== 1'b1 || a_oob_cnt !== 4'd2
          || a_wr_oob !== 1'b0) begin
         fails++; $display("[TB] FAIL oob_read: got d%h r%b v%b c%0d w%b expected dff r1 v1 c2 w0",
                           a_rd_data, a_rd_oob, a_rd_valid, a_oob_cnt, a_wr_oob);
      end
   endtask

   task automatic test_bypass();
      cyc(0, 0, 1, 3'd2, 16'h005a, 1, 3'd2);
      tests_run++;
      if (a_rd_data !== 8'hff) begin
         fails++; $display("[TB] FAIL bypass_off: got %h expected ff", a_rd_data);
      end
      tests_run++;
      if (b_rd_data !== 16'h005a) begin
         fails++; $display("[TB] FAIL bypass_on: got %h expected 005a", b_rd_data);
      end
      cyc(0, 0, 0, 0, 0, 1, 3'd2);
      tests_run++;
      if (a_rd_data !== 8'h5a || b_rd_data !== 16'h005a) begin
         fails++; $display("[TB] FAIL bypass_next: got a%h b%h expected a5a b005a", a_rd_data, b_rd_data);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 3'd7, 16'h1234, 1, 3'd7);
      tests_run++;
      if (a_oob_cnt !== 4'hf || b_oob_cnt !== 4'hf) begin
         fails++; $display("[TB] FAIL saturate: got a%h b%h expected f f", a_oob_cnt, b_oob_cnt);
      end
      cyc(1, 0, 0, 0, 0, 0, 0);
      tests_run++;
      if (a_oob_cnt !== 4'h0 || a_s_o !== 48'hffff_ffff_ffff) begin
         fails++; $display("[TB] FAIL saturate_reset: got c%h s%h expected c0 s all ones", a_oob_cnt, a_s_o);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, 3'(i), 16'(16'h1111 * (i + 1)), 0, 0);
      tests_run++;
      if (b_s_o !== 128'hffff_1111_2222_3333_4444_5555_6666_ffff) begin
         fails++; $display("[TB] FAIL clear_prefill: got %h", b_s_o);
      end
      cyc(0, 1, 1, 3'd3, 16'hbeef, 1, 3'd3);
      tests_run++;
      if (b_rd_data !== 16'h4444 || a_rd_data !== 8'h44) begin
         fails++; $display("[TB] FAIL clear_read_old: got b%h a%h expected b4444 a44", b_rd_data, a_rd_data);
      end
      tests_run++;
      if (b_s_o !== {128{1'b1}} || a_s_o !== 48'hffff_ffff_ffff) begin
         fails++; $display("[TB] FAIL clear_lanes: got b%h a%h expected all ones", b_s_o, a_s_o);
      end
   endtask

   task automatic test_random();
      logic [127:0] es;
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), 1'($urandom),
             3'($urandom), 16'($urandom), 1'($urandom), 3'($urandom));
         es = exp_s(0);
         tests_run++;
         if ({a_rd_data, a_rd_valid, a_rd_oob, a_wr_oob, a_oob_cnt, a_s_o} !==
             {m_rd[0][7:0], m_valid[0], m_rdoob[0], m_wroob[0], 4'(m_cnt[0]), es[47:0]}) begin
            fails++; $display("[TB] FAIL random_a cycle %0d: got d%h v%b r%b w%b c%0d s%h expected d%h v%b r%b w%b c%0d s%h",
                              n, a_rd_data, a_rd_valid, a_rd_oob, a_wr_oob, a_oob_cnt, a_s_o,
                              m_rd[0][7:0], m_valid[0], m_rdoob[0], m_wroob[0], m_cnt[0], es[47:0]);
         end
         es = exp_s(1);
         tests_run++;
         if ({b_rd_data, b_rd_valid, b_rd_oob, b_wr_oob, b_oob_cnt, b_s_o} !==
             {m_rd[1], m_valid[1], m_rdoob[1], m_wroob[1], 4'(m_cnt[1]), es}) begin
            fails++; $display("[TB] FAIL random_b cycle %0d: got d%h v%b r%b w%b c%0d s%h expected d%h v%b r%b w%b c%0d s%h",
                              n, b_rd_data, b_rd_valid, b_rd_oob, b_wr_oob, b_oob_cnt, b_s_o,
                              m_rd[1], m_valid[1], m_rdoob[1], m_wroob[1], m_cnt[1], es);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_oob();
      test_bypass();
      test_saturate();
      test_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
